// File: rtl/ntt_len_switch_ctrl_if.sv
// Bundle of the length-change handshake and pipeline occupancy signals seen by
// the NTT length-switch controller. The controller takes the slave modport.
interface ntt_len_switch_ctrl_if #(
  parameter int unsigned MAX_LEN      = 1024,
  parameter int unsigned MAX_INFLIGHT = 8
);
  localparam int unsigned STAGES = $clog2(MAX_LEN);
  localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1;
  localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT + 1);

  logic               cfg_req_valid;
  logic [LEN_W-1:0]   cfg_req_len;
  logic               cfg_req_ready;
  logic               cfg_done;
  logic               cfg_err;
  logic [LEN_W-1:0]   active_length;
  logic [STAGES-1:0]  stage_bypass;
  logic               in_fifo_empty;
  logic               entry_empty;
  logic               in_rd_finish;
  logic               out_rd_finish;
  logic               ROB_empty_NTT;
  logic [CNT_W-1:0]   inflight;
  logic               underflow_err;

  modport slave (
    input  cfg_req_valid, cfg_req_len, in_fifo_empty, in_rd_finish, out_rd_finish,
           ROB_empty_NTT,
    output cfg_req_ready, cfg_done, cfg_err, active_length, stage_bypass, entry_empty,
           inflight, underflow_err
  );

  modport master (
    output cfg_req_valid, cfg_req_len, in_fifo_empty, in_rd_finish, out_rd_finish,
           ROB_empty_NTT,
    input  cfg_req_ready, cfg_done, cfg_err, active_length, stage_bypass, entry_empty,
           inflight, underflow_err
  );
endinterface

// File: rtl/ntt_len_switch_ctrl.sv
// NTT length-switch controller: owns the active length and the per-stage bypass
// mask, counts polynomials in flight, and only applies a new length once the
// pipeline and ROB have fully drained.
module ntt_len_switch_ctrl #(
  parameter int unsigned MAX_LEN      = 1024,
  parameter int unsigned MIN_LEN      = 256,
  parameter int unsigned STAGES       = $clog2(MAX_LEN),
  parameter int unsigned LEN_W        = $clog2(MAX_LEN) + 1,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned SETTLE_CYC   = 2
) (
  input logic                   clk,
  input logic                   rstn,
  ntt_len_switch_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {StRun, StDrain, StSwitch} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   active_len_q;
  logic [LEN_W-1:0]   pend_len_q, pend_len_d;
  logic [STAGES-1:0]  bypass_q, new_bypass;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               underflow_q, underflow_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready, hold_fsm, load_len;
  logic               len_pow2, len_in_range, pipe_drained, pipe_full;

  // Request legality: power of two within [MIN_LEN, MAX_LEN].
  always_comb begin
    len_pow2     = (bus.cfg_req_len != '0) &&
                   ((bus.cfg_req_len & (bus.cfg_req_len - LEN_W'(1))) == '0);
    len_in_range = (bus.cfg_req_len >= LEN_W'(MIN_LEN)) &&
                   (bus.cfg_req_len <= LEN_W'(MAX_LEN));
  end

  // Bypass mask for the pending length: stage s is skipped when the length is
  // no larger than MAX_LEN >> (STAGES - s), which sets the top k bits.
  always_comb begin
    new_bypass = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      if ((MAX_LEN >> (STAGES - s)) >= 32'(pend_len_q)) begin
        new_bypass[s] = 1'b1;
      end
    end
  end

  assign pipe_full    = (inflight_q == CNT_W'(MAX_INFLIGHT));
  assign pipe_drained = (inflight_q == '0) && bus.ROB_empty_NTT &&
                        !bus.in_rd_finish && !bus.out_rd_finish;

  // Next-state, handshake and pulse decode.
  always_comb begin
    state_d    = state_q;
    pend_len_d = pend_len_q;
    settle_d   = settle_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ready      = 1'b0;
    hold_fsm   = 1'b0;
    load_len   = 1'b0;
    unique case (state_q)
      StRun: begin
        ready = 1'b1;
        if (bus.cfg_req_valid) begin
          if (!(len_pow2 && len_in_range)) begin
            err_d = 1'b1;
          end else if (bus.cfg_req_len == active_len_q) begin
            done_d = 1'b1;
          end else begin
            pend_len_d = bus.cfg_req_len;
            state_d    = StDrain;
          end
        end
      end
      StDrain: begin
        hold_fsm = 1'b1;
        if (pipe_drained) begin
          state_d  = StSwitch;
          load_len = 1'b1;
          settle_d = '0;
        end
      end
      StSwitch: begin
        hold_fsm = 1'b1;
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Inflight count; saturates at MAX_INFLIGHT and flags a decrement at zero.
  always_comb begin
    inflight_d  = inflight_q;
    underflow_d = underflow_q;
    if (bus.in_rd_finish && !bus.out_rd_finish) begin
      if (!pipe_full) inflight_d = inflight_q + CNT_W'(1);
    end else if (bus.out_rd_finish && !bus.in_rd_finish) begin
      if (inflight_q == '0) underflow_d = 1'b1;
      else                  inflight_d  = inflight_q - CNT_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StRun;
      active_len_q <= LEN_W'(MAX_LEN);
      pend_len_q   <= LEN_W'(MAX_LEN);
      bypass_q     <= '0;
      settle_q     <= '0;
      inflight_q   <= '0;
      underflow_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_len_q  <= pend_len_d;
      settle_q    <= settle_d;
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
      done_q      <= done_d;
      err_q       <= err_d;
      if (load_len) begin
        active_len_q <= pend_len_q;
        bypass_q     <= new_bypass;
      end
    end
  end

  // Outputs; the entry stage is starved while switching or when the pipe is full.
  always_comb begin
    bus.cfg_req_ready = ready;
    bus.cfg_done      = done_q;
    bus.cfg_err       = err_q;
    bus.active_length = active_len_q;
    bus.stage_bypass  = bypass_q;
    bus.entry_empty   = bus.in_fifo_empty | hold_fsm | pipe_full;
    bus.inflight      = inflight_q;
    bus.underflow_err = underflow_q;
  end

endmodule

// File: doc/ntt_len_switch_ctrl.md
Name: ntt_len_switch_ctrl

Overview:
Sequential controller for the NTT pipeline that generalises the fixed two-length leading-stage bypass to any power-of-two length from MIN_LEN to MAX_LEN. It owns the active length, drives a per-stage bypass mask to the stage muxes in the NTT top, and tracks polynomials in flight. A length change is applied only after the pipeline has fully drained, so no polynomial ever sees a mixed configuration.

Parameters:
MAX_LEN, 1024, largest supported NTT length (power of two)
MIN_LEN, 256, smallest supported NTT length (power of two, <= MAX_LEN)
STAGES, $clog2(MAX_LEN), number of NTT stages
LEN_W, $clog2(MAX_LEN)+1, width of the length fields
MAX_INFLIGHT, 8, maximum polynomials admitted into the pipeline
SETTLE_CYC, 2, idle cycles held after a switch before new input is admitted

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
cfg_req_valid  in  1  length-change request
cfg_req_len  in  LEN_W  requested length
cfg_req_ready  out  1  request accepted this cycle when valid&ready
cfg_done  out  1  one-cycle pulse when the new length is active
cfg_err  out  1  one-cycle pulse when a request is illegal
active_length  out  LEN_W  length currently applied to the pipeline
stage_bypass  out  STAGES  bit s=1: stage s is bypassed by its mux
in_fifo_empty  in  1  empty flag from the input FIFO
entry_empty  out  1  empty flag presented to the entry stage
in_rd_finish  in  1  pulse: entry stage finished reading one polynomial
out_rd_finish  in  1  pulse: downstream finished reading one polynomial from stage 0
ROB_empty_NTT  in  1  ROB holds no pending NTT results
inflight  out  $clog2(MAX_INFLIGHT+1)  polynomials currently in the pipeline
underflow_err  out  1  sticky flag: out_rd_finish seen while inflight==0

Behaviour:
- Reset values: active_length=MAX_LEN, stage_bypass=0, inflight=0, state=RUN, cfg_req_ready=1, cfg_done=0, cfg_err=0, underflow_err=0, entry_empty=in_fifo_empty.
- stage_bypass is fully registered: bits [STAGES-1 : STAGES-k] are set, where k=log2(MAX_LEN)-log2(active_length). All other bits are clear.
- entry_empty = in_fifo_empty | hold. The internal hold is 1 in DRAIN and SWITCH, and also whenever inflight==MAX_INFLIGHT.
- Inflight counter:
  - increments on in_rd_finish and decrements on out_rd_finish; both in the same cycle leave it unchanged.
  - It never exceeds MAX_INFLIGHT.
  - A decrement at 0 holds the count at 0 and sets underflow_err, which is cleared only by reset.
- State RUN: cfg_req_ready=1. On valid&ready:
  - If cfg_req_len is not a power of two or lies outside [MIN_LEN, MAX_LEN]: cfg_err pulses the next cycle and the state stays RUN.
  - If cfg_req_len equals active_length: cfg_done pulses the next cycle with no drain.
  - Otherwise: latch the pending length and go to DRAIN.
- State DRAIN: cfg_req_ready=0 and hold=1. Go to SWITCH on the first cycle that inflight==0, ROB_empty_NTT==1 and no in_rd_finish or out_rd_finish pulse is present.
- State SWITCH:
  - On entry, register active_length and stage_bypass from the pending length.
  - Keep hold=1 for SETTLE_CYC cycles counted from entry, then return to RUN with a one-cycle cfg_done pulse. The new bypass is therefore stable for at least SETTLE_CYC cycles before any read.
- An in_rd_finish arriving in DRAIN is still counted, because the entry stage may have started before hold rose. DRAIN waits for that polynomial to finish.
- Reset in any state returns immediately to the reset values. A pending length is discarded.
- cfg_req_valid while ready=0 is ignored. The requester keeps valid asserted until it sees ready.

Test Plan:
- Reset then idle -> active_length=1024, stage_bypass=10'h000, cfg_req_ready=1, entry_empty follows in_fifo_empty.
- Request 256 with inflight=0 and ROB empty -> DRAIN lasts 1 cycle, SWITCH holds 2 cycles, cfg_done pulses, stage_bypass=10'h300, active_length=256.
- Request 512 with inflight=3 and ROB not empty -> entry_empty=1 throughout. Switch occurs only after three out_rd_finish pulses and ROB_empty_NTT=1; then stage_bypass=10'h200.
- Request 300, then 128, then 2048 -> cfg_err pulses for each, no state change, active_length unchanged.
- Issue 8 in_rd_finish pulses with no out_rd_finish -> inflight=8 and entry_empty=1 while in_fifo_empty=0. A simultaneous in/out pulse pair keeps inflight=8. One out_rd_finish releases the hold.
- out_rd_finish at inflight=0 -> inflight stays 0 and underflow_err=1 until rstn is asserted. Asserting rstn low during DRAIN of a 256 request -> active_length=1024, state RUN.
